// File: rtl/regfile_sweep_clr.sv
// regfile_sweep_clr: DEPTH x WIDTH register bank, one write port, two
// combinational read ports, and a sweep-clear sequencer (IDLE/CLEAR/DONE)
// that zeroes one entry per cycle while reporting busy/clr_done.
// Writes that cannot be honoured (out of range, or while busy) are dropped
// and flagged with a one-cycle wr_err pulse.
// Optional build macro: REGFILE_WR_BYPASS_EN -- forwards an accepted write
// to any read port addressing the same entry in the same cycle.
module regfile_sweep_clr #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr0,
    output logic [WIDTH-1:0]  rd_data0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [WIDTH-1:0]  rd_data1,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // One extra bit so DEPTH == 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              r_busy;
    logic              r_done;
    logic              r_wr_err;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_wr_err_nxt;
    logic              w_wr_in_range;
    logic              w_wr_ok;
    logic              w_clr_en;
    logic [WIDTH-1:0]  w_rd0;
    logic [WIDTH-1:0]  w_rd1;

    assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH_C);

    // State, sweep pointer and registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_wr_err <= w_wr_err_nxt;
        end
    end

    // Next-state, pointer advance, write acceptance and status decode.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_wr_ok     = 1'b0;
        w_clr_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A write in the same cycle as clr_req still lands; the
                // sweep that follows clears it again.
                w_wr_ok = we && w_wr_in_range;
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_clr_en = 1'b1;
                if (r_ptr == LAST_C) begin
                    // Park the pointer at 0 so it never exceeds DEPTH-1.
                    w_state_nxt = S_DONE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_done_nxt   = (w_state_nxt == S_DONE);
        // Any requested write that is not accepted is a dropped write.
        w_wr_err_nxt = we && !w_wr_ok;
    end

    // Storage array: accepted writes in IDLE, one-entry-per-cycle sweep in CLEAR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end else if (w_clr_en) begin
            r_mem[r_ptr] <= '0;
        end
    end

    // Read port 0: out-of-range addresses read as zero.
    always_comb begin
        w_rd0 = '0;
        if ({1'b0, rd_addr0} < DEPTH_C) begin
            w_rd0 = r_mem[rd_addr0];
        end
`ifdef REGFILE_WR_BYPASS_EN
        if (w_wr_ok && (rd_addr0 == wr_addr)) begin
            w_rd0 = wr_data;
        end
`endif
    end

    // Read port 1: same rules as port 0, independent address.
    always_comb begin
        w_rd1 = '0;
        if ({1'b0, rd_addr1} < DEPTH_C) begin
            w_rd1 = r_mem[rd_addr1];
        end
`ifdef REGFILE_WR_BYPASS_EN
        if (w_wr_ok && (rd_addr1 == wr_addr)) begin
            w_rd1 = wr_data;
        end
`endif
    end

    assign rd_data0 = w_rd0;
    assign rd_data1 = w_rd1;
    assign busy     = r_busy;
    assign clr_done = r_done;
    assign wr_err   = r_wr_err;

endmodule

// File: tb/tb_regfile_sweep_clr.sv
// Bench for regfile_sweep_clr: directed scenarios plus a randomized run,
// checked against a cycle-level reference model of the register bank.
// A second DEPTH=6 instance covers the out-of-range address behaviour.
module tb_regfile_sweep_clr;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       we = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [2:0] rd_addr0 = '0;
    logic [2:0] rd_addr1 = '0;
    logic       clr_req = 1'b0;
    logic [7:0] rd_data0, rd_data1;
    logic       busy, clr_done, wr_err;

    logic       we6 = 1'b0;
    logic [2:0] wa6 = '0;
    logic [7:0] wd6 = '0;
    logic [2:0] ra6_0 = '0;
    logic [2:0] ra6_1 = '0;
    logic [7:0] rd6_0, rd6_1;
    logic       busy6, done6, err6;

    int checks = 0;
    int failures = 0;

    // Reference model: array contents, sweep progress (0 = idle,
    // k in 1..D = k-th clear cycle, D+1 = done cycle), expected wr_err.
    logic [7:0] m_mem [D];
    int         m_sw = 0;
    logic       m_err = 1'b0;

    regfile_sweep_clr #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(rd_data0), .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .wr_err(wr_err)
    );

    regfile_sweep_clr #(.WIDTH(8), .DEPTH(6), .ADDR_W(3)) dut6 (
        .clk(clk), .reset_n(reset_n), .we(we6), .wr_addr(wa6), .wr_data(wd6),
        .rd_addr0(ra6_0), .rd_data0(rd6_0), .rd_addr1(ra6_1), .rd_data1(rd6_1),
        .clr_req(1'b0), .busy(busy6), .clr_done(done6), .wr_err(err6)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_rd(input logic [2:0] a);
`ifdef REGFILE_WR_BYPASS_EN
        if (m_sw == 0 && we && int'(wr_addr) < D && a == wr_addr) return wr_data;
`endif
        if (int'(a) >= D) return 8'h00;
        return m_mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = 8'h00;
        m_sw  = 0;
        m_err = 1'b0;
    endtask

    // Advance one clock: model consumes the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        m_err = we && (m_sw != 0 || int'(wr_addr) >= D);
        if (m_sw == 0) begin
            if (we && int'(wr_addr) < D) m_mem[wr_addr] = wr_data;
            if (clr_req) m_sw = 1;
        end else if (m_sw <= D) begin
            m_mem[m_sw-1] = 8'h00;
            m_sw++;
        end else begin
            m_sw = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < D; a++) begin
            rd_addr0 = 3'(a);
            rd_addr1 = 3'(D - 1 - a);
            #1;
            checks++;
            if (rd_data0 !== 8'h00) begin failures++; $display("FAIL reset_rd0 a=%0d got=%h exp=00", a, rd_data0); end
            checks++;
            if (rd_data1 !== 8'h00) begin failures++; $display("FAIL reset_rd1 a=%0d got=%h exp=00", D-1-a, rd_data1); end
        end
        checks++;
        if ({busy, clr_done, wr_err} !== 3'b000) begin
            failures++; $display("FAIL reset_status got=%b exp=000", {busy, clr_done, wr_err});
        end
    endtask

    task automatic test_dual_read();
        we = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; tick();
        wr_addr = 3'd6; wr_data = 8'h5A; tick();
        we = 1'b0; rd_addr0 = 3'd3; rd_addr1 = 3'd6; #1;
        checks++;
        if (rd_data0 !== 8'hA5) begin failures++; $display("FAIL dual_rd0 got=%h exp=a5", rd_data0); end
        checks++;
        if (rd_data1 !== 8'h5A) begin failures++; $display("FAIL dual_rd1 got=%h exp=5a", rd_data1); end
        checks++;
        if (wr_err !== 1'b0) begin failures++; $display("FAIL dual_wr_err got=%b exp=0", wr_err); end
    endtask

    task automatic test_sweep();
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at = -1;
        for (int i = 0; i < D; i++) begin
            we = 1'b1; wr_addr = 3'(i); wr_data = 8'(8'h11 * (i + 1)); tick();
        end
        we = 1'b0;
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (busy !== (m_sw != 0) || clr_done !== (m_sw == D + 1)) begin
                failures++; $display("FAIL sweep_status c=%0d got=%b%b exp=%b%b", c, busy, clr_done, m_sw != 0, m_sw == D + 1);
            end
            if (busy === 1'b1) busy_cnt++;
            if (clr_done === 1'b1) begin done_cnt++; done_at = busy_cnt; end
            if (c == 4) begin
                rd_addr0 = 3'd2; rd_addr1 = 3'd5; #1;
                checks++;
                if (rd_data0 !== 8'h00) begin failures++; $display("FAIL sweep_mid_swept got=%h exp=00", rd_data0); end
                checks++;
                if (rd_data1 !== 8'h66) begin failures++; $display("FAIL sweep_mid_unswept got=%h exp=66", rd_data1); end
            end
            tick();
        end
        checks++;
        if (busy_cnt != 9 || done_cnt != 1 || done_at != 9) begin
            failures++; $display("FAIL sweep_timing busy=%0d done=%0d at=%0d exp=9/1/9", busy_cnt, done_cnt, done_at);
        end
        for (int a = 0; a < D; a++) begin
            rd_addr0 = 3'(a); #1;
            checks++;
            if (rd_data0 !== 8'h00) begin failures++; $display("FAIL sweep_after a=%0d got=%h exp=00", a, rd_data0); end
        end
    endtask

    task automatic test_write_busy();
        we = 1'b1; wr_addr = 3'd1; wr_data = 8'h42; tick();
        we = 1'b0; clr_req = 1'b1; tick(); clr_req = 1'b0;
        we = 1'b1; wr_addr = 3'd1; wr_data = 8'hFF; rd_addr0 = 3'd1; #1;
        checks++;
        if (rd_data0 !== 8'h42) begin failures++; $display("FAIL busy_no_forward got=%h exp=42", rd_data0); end
        tick(); we = 1'b0;
        checks++;
        if (wr_err !== 1'b1) begin failures++; $display("FAIL busy_wr_err got=%b exp=1", wr_err); end
        tick();
        checks++;
        if (wr_err !== 1'b0) begin failures++; $display("FAIL busy_wr_err_pulse got=%b exp=0", wr_err); end
        for (int g = 0; g < 20 && m_sw != D + 1; g++) tick();
        checks++;
        if (clr_done !== 1'b1) begin failures++; $display("FAIL busy_reach_done got=%b exp=1", clr_done); end
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL done_no_restart got=%b exp=0", busy); end
        tick();
        rd_addr0 = 3'd1; #1;
        checks++;
        if (busy !== 1'b0 || rd_data0 !== 8'h00) begin
            failures++; $display("FAIL busy_after busy=%b rd=%h exp=0/00", busy, rd_data0);
        end
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 6; i++) begin
            we6 = 1'b1; wa6 = 3'(i); wd6 = 8'(8'hC0 + i); tick();
        end
        checks++;
        if (err6 !== 1'b0) begin failures++; $display("FAIL oor_last_ok got=%b exp=0", err6); end
        wa6 = 3'd7; wd6 = 8'hEE; tick(); we6 = 1'b0;
        checks++;
        if (err6 !== 1'b1) begin failures++; $display("FAIL oor_wr_err got=%b exp=1", err6); end
        tick();
        checks++;
        if (err6 !== 1'b0) begin failures++; $display("FAIL oor_pulse got=%b exp=0", err6); end
        for (int i = 0; i < 6; i++) begin
            ra6_0 = 3'(i); #1;
            checks++;
            if (rd6_0 !== 8'(8'hC0 + i)) begin failures++; $display("FAIL oor_entry a=%0d got=%h exp=%h", i, rd6_0, 8'(8'hC0 + i)); end
        end
        ra6_0 = 3'd7; ra6_1 = 3'd6; #1;
        checks++;
        if (rd6_0 !== 8'h00 || rd6_1 !== 8'h00) begin
            failures++; $display("FAIL oor_read got=%h/%h exp=00/00", rd6_0, rd6_1);
        end
    endtask

    task automatic test_reset_mid_sweep();
        for (int i = 0; i < D; i++) begin
            we = 1'b1; wr_addr = 3'(i); wr_data = 8'($urandom_range(1, 255)); tick();
        end
        we = 1'b0; clr_req = 1'b1; tick(); clr_req = 1'b0;
        tick(); tick();
        #2 reset_n = 1'b0; model_reset(); #1;
        checks++;
        if (busy !== 1'b0 || clr_done !== 1'b0) begin
            failures++; $display("FAIL rst_mid_status got=%b%b exp=00", busy, clr_done);
        end
        for (int a = 0; a < D; a++) begin
            rd_addr0 = 3'(a); #1;
            checks++;
            if (rd_data0 !== 8'h00) begin failures++; $display("FAIL rst_mid_entry a=%0d got=%h exp=00", a, rd_data0); end
        end
        @(negedge clk); reset_n = 1'b1;
        for (int c = 0; c < D + 3; c++) begin
            tick();
            checks++;
            if (clr_done !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL rst_mid_no_done c=%0d got=%b%b exp=00", c, busy, clr_done);
            end
        end
    endtask

    task automatic test_bypass();
        logic [7:0] exp0;
        we = 1'b1; wr_addr = 3'd2; wr_data = 8'h77; tick();
        wr_data = 8'h3C; rd_addr0 = 3'd2; rd_addr1 = 3'd5; #1;
`ifdef REGFILE_WR_BYPASS_EN
        exp0 = 8'h3C;
`else
        exp0 = 8'h77;
`endif
        checks++;
        if (rd_data0 !== exp0) begin failures++; $display("FAIL bypass_same got=%h exp=%h", rd_data0, exp0); end
        checks++;
        if (rd_data1 !== m_mem[5]) begin failures++; $display("FAIL bypass_other got=%h exp=%h", rd_data1, m_mem[5]); end
        tick(); we = 1'b0; #1;
        checks++;
        if (rd_data0 !== 8'h3C) begin failures++; $display("FAIL bypass_next got=%h exp=3c", rd_data0); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            we       = 1'($urandom_range(0, 1));
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 8'($urandom_range(0, 255));
            clr_req  = ($urandom_range(0, 15) == 0);
            rd_addr0 = 3'($urandom_range(0, 7));
            rd_addr1 = (n % 3 == 0) ? wr_addr : 3'($urandom_range(0, 7));
            #1;
            checks++;
            if (rd_data0 !== exp_rd(rd_addr0) || rd_data1 !== exp_rd(rd_addr1)) begin
                failures++; $display("FAIL rand_read n=%0d got=%h/%h exp=%h/%h", n, rd_data0, rd_data1, exp_rd(rd_addr0), exp_rd(rd_addr1));
            end
            tick();
            checks++;
            if (busy !== (m_sw != 0) || clr_done !== (m_sw == D + 1) || wr_err !== m_err) begin
                failures++; $display("FAIL rand_status n=%0d got=%b%b%b exp=%b%b%b", n, busy, clr_done, wr_err, m_sw != 0, m_sw == D + 1, m_err);
            end
        end
        we = 1'b0; clr_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dual_read();
        test_sweep();
        test_write_busy();
        test_out_of_range();
        test_reset_mid_sweep();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
